divisor_3b: RTL and testbench

- Sequential unsigned restoring divider (shift/subtract).
- Computes quotient and remainder of portA / portB, one quotient bit per two clocks.
- Started by a level START request; completion is flagged by DONE.
- Used as a small arithmetic coprocessor under control of a sequencer that raises START and waits for DONE.

---
 rtl/divisor_3b.sv | 104 ++++++++++
 tb/tb_divisor_3b.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/divisor_3b.sv
// Sequential unsigned restoring divider: one quotient bit every two clocks,
// started by a level START, result held on DV/REM with DONE while in FIN.
//
// state | meaning
// IDLE  | waiting for START, DONE low, last result held
// LOAD  | latch operands, clear partial remainder, trap divide-by-zero
// SHIFT | shift {R,A} left one bit, count the bit
// SUB   | trial subtract, set quotient bit, finish after the last bit
// FIN   | DONE high, hold until START is released
module divisor_3b #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] portA,
   input  logic [WIDTH-1:0] portB,
   input  logic             START,
   output logic [WIDTH-1:0] DV,
   output logic [WIDTH-1:0] REM,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SUB, FIN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, dv_q, rem_q;
   logic [WIDTH:0]   r_q;
   logic [CW-1:0]    i_q;
   logic             done_q;

   logic             r_ge_d;
   logic [WIDTH:0]   r_d;
   logic [WIDTH-1:0] a_d;

   // Trial subtraction for the SUB step; R is one bit wider than B so the
   // shifted-in dividend bit is never lost.
   always_comb begin
      r_ge_d = (r_q >= {1'b0, b_q});
      r_d    = r_ge_d ? (r_q - {1'b0, b_q}) : r_q;
      a_d    = {a_q[WIDTH-1:1], r_ge_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         i_q     <= '0;
         dv_q    <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (START) state_q <= LOAD;
            end
            LOAD: begin
               a_q <= portA;
               b_q <= portB;
               r_q <= '0;
               i_q <= CW'(WIDTH);
               if (portB == '0) begin
                  dv_q    <= '1;
                  rem_q   <= portA;
                  state_q <= FIN;
               end else begin
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               r_q     <= {r_q[WIDTH-1:0], a_q[WIDTH-1]};
               a_q     <= {a_q[WIDTH-2:0], 1'b0};
               i_q     <= i_q - CW'(1);
               state_q <= SUB;
            end
            SUB: begin
               r_q <= r_d;
               a_q <= a_d;
               if (i_q == '0) begin
                  dv_q    <= a_d;
                  rem_q   <= r_d[WIDTH-1:0];
                  state_q <= FIN;
               end else begin
                  state_q <= SHIFT;
               end
            end
            FIN: begin
               done_q <= 1'b1;
               if (!START) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign DV   = dv_q;
   assign REM  = rem_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_divisor_3b.sv
// Scoreboard bench for divisor_3b: expected quotient/remainder/latency are
// queued at START and compared when DONE rises.
module tb_divisor_3b;

   localparam int WIDTH = 3;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] portA, portB;
   logic             START;
   logic [WIDTH-1:0] DV, REM;
   logic             DONE;

   typedef struct {
      int dv;
      int rem;
      int lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   divisor_3b #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .portA (portA),
      .portB (portB),
      .START (START),
      .DV    (DV),
      .REM   (REM),
      .DONE  (DONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_exp(input int a, input int b);
      exp_t e;
      if (b == 0) begin
         e.dv  = (1 << WIDTH) - 1;
         e.rem = a;
         e.lat = 2;
      end else begin
         e.dv  = a / b;
         e.rem = a % b;
         e.lat = 2 * WIDTH + 2;
      end
      sb.push_back(e);
   endtask

   // n0 is the index of the next clock edge, counting the edge that samples START as 0.
   task automatic wait_done(input int n0);
      exp_t e;
      int   n;
      bit   hit;
      n   = n0;
      hit = 1'b0;
      while (!hit && n < 40) begin
         @(posedge clk);
         #1;
         if (DONE) hit = 1'b1;
         else n++;
      end
      check_val("done_seen", int'(hit), 1);
      if (sb.size() == 0) begin
         check_val("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check_val("latency", n, e.lat);
         check_val("dv", int'(DV), e.dv);
         check_val("rem", int'(REM), e.rem);
      end
   endtask

   task automatic drive_start(input int a, input int b);
      @(negedge clk);
      portA = WIDTH'(a);
      portB = WIDTH'(b);
      START = 1'b1;
      push_exp(a, b);
   endtask

   task automatic release_start(input int dv_exp, input int rem_exp);
      @(negedge clk);
      START = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("done_fall", int'(DONE), 0);
      check_val("dv_hold", int'(DV), dv_exp);
      check_val("rem_hold", int'(REM), rem_exp);
   endtask

   initial begin
      rst_n = 1'b0;
      START = 1'b0;
      portA = '0;
      portB = '0;
      #2;
      check_val("rst_dv", int'(DV), 0);
      check_val("rst_rem", int'(REM), 0);
      check_val("rst_done", int'(DONE), 0);
      #10;
      rst_n = 1'b1;

      // 7/5 started at 18 ns, START held well past completion
      #6;
      portA = 3'd7;
      portB = 3'd5;
      START = 1'b1;
      push_exp(7, 5);
      wait_done(0);
      for (int k = 0; k < 20; k++) begin
         #100;
         check_val("hold_done", int'(DONE), 1);
         check_val("hold_dv", int'(DV), 1);
      end
      release_start(1, 2);

      drive_start(6, 2);
      wait_done(0);
      release_start(3, 0);

      drive_start(5, 0);
      wait_done(0);
      release_start(7, 5);

      drive_start(2, 7);
      wait_done(0);
      release_start(0, 2);
      drive_start(7, 1);
      wait_done(0);
      release_start(7, 0);

      // operands change once the divider is already in SHIFT
      drive_start(7, 5);
      @(posedge clk);
      @(posedge clk);
      #1;
      portA = 3'd3;
      portB = 3'd3;
      wait_done(2);
      release_start(1, 2);

      // reset while the first SUB of a 7/3 run is in progress
      drive_start(7, 3);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("abort_dv", int'(DV), 0);
      check_val("abort_rem", int'(REM), 0);
      check_val("abort_done", int'(DONE), 0);
      sb.delete();
      START = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_start(7, 3);
      wait_done(0);
      release_start(2, 1);

      for (int k = 0; k < 8; k++) begin
         int a, b;
         a = int'($urandom_range(0, 7));
         b = int'($urandom_range(0, 7));
         drive_start(a, b);
         wait_done(0);
         if (b == 0) release_start(7, a);
         else release_start(a / b, a % b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
